// File: rtl/gp_dram_arbiter.sv
// gp_dram_arbiter: shares one DRAM request interface (af/wdf/rdf) between graphics requesters.
// Round-robin issue with one command in flight; read bursts are tagged so the two returned
// rdf beats are steered to the requester that issued them.
// Optional: define GP_ARB_RDPRIO_EN so eligible reads win over every write.
module gp_dram_arbiter #(
  parameter int unsigned NREQ     = 3,
  parameter int unsigned RD_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           req_we,
  input  logic [NREQ*31-1:0]        req_addr,
  input  logic [NREQ*256-1:0]       req_wdata,
  input  logic [NREQ*32-1:0]        req_wmask,
  output logic [NREQ-1:0]           gnt,
  output logic [127:0]              rd_data,
  output logic [NREQ-1:0]           rd_valid,
  input  logic                      af_full,
  output logic                      af_wr_en,
  output logic [2:0]                af_cmd_din,
  output logic [30:0]               af_addr_din,
  input  logic                      wdf_full,
  output logic                      wdf_wr_en,
  output logic [127:0]              wdf_data_din,
  output logic [15:0]               wdf_mask_din,
  input  logic                      rdf_valid,
  input  logic [127:0]              rdf_dout,
  output logic                      rdf_rd_en,
  output logic [$clog2(RD_DEPTH):0] rd_outstanding
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned AW = $clog2(RD_DEPTH);

  typedef enum logic [1:0] {StIdle, StCmd, StWd0, StWd1} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q;
  logic            we_q;
  logic [30:0]     addr_q;
  logic [255:0]    wdata_q;
  logic [31:0]     wmask_q;
  logic [NREQ-1:0] gnt_q;

  logic [NREQ-1:0] elig, cand, sel_oh;
  logic [IW:0]     rr_idx;
  logic [IW-1:0]   sel_idx;
  logic            sel_vld, sel_we;
  logic [30:0]     sel_addr;
  logic [255:0]    sel_wdata;
  logic [31:0]     sel_wmask;

  logic [IW-1:0]   tag_mem [RD_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     cnt_q;
  logic            beat_q;
  logic            tag_full, tag_empty, tag_push, tag_pop;
  logic [IW-1:0]   head_tag;

  assign tag_empty = (cnt_q == '0);
  assign tag_full  = (cnt_q == (AW+1)'(RD_DEPTH));
  assign head_tag  = tag_mem[rd_ptr_q];
  // Second beat of a tagged burst retires the tag.
  assign tag_pop   = rdf_valid & ~tag_empty & beat_q;

  // Eligibility and round-robin winner search starting just after the pointer.
  always_comb begin
    for (int i = 0; i < int'(NREQ); i++) begin
      elig[i] = req[i] & (req_we[i] | ~tag_full);
    end
`ifdef GP_ARB_RDPRIO_EN
    cand = ((elig & ~req_we) != '0) ? (elig & ~req_we) : elig;
`else
    cand = elig;
`endif
    sel_vld = 1'b0;
    sel_idx = '0;
    rr_idx  = '0;
    // Walk from farthest to nearest so the nearest candidate is written last.
    for (int k = int'(NREQ); k >= 1; k--) begin
      rr_idx = {1'b0, ptr_q} + (IW+1)'(k);
      if (rr_idx >= (IW+1)'(NREQ)) rr_idx = rr_idx - (IW+1)'(NREQ);
      if (cand[rr_idx[IW-1:0]]) begin
        sel_vld = 1'b1;
        sel_idx = rr_idx[IW-1:0];
      end
    end
  end

  // Mux the winning requester's command fields.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wmask = '0;
    sel_oh    = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (sel_idx == IW'(i)) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[31*i +: 31];
        sel_wdata = req_wdata[256*i +: 256];
        sel_wmask = req_wmask[32*i +: 32];
        sel_oh[i] = sel_vld;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Command latch, round-robin pointer and registered grant pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= IW'(NREQ - 1);
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      gnt_q   <= '0;
    end else begin
      gnt_q <= '0;
      if (state_q == StIdle && sel_vld) begin
        gnt_q   <= sel_oh;
        ptr_q   <= sel_idx;
        we_q    <= sel_we;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        wmask_q <= sel_wmask;
      end
    end
  end

  // Issue FSM next state and af/wdf outputs.
  always_comb begin
    state_d      = state_q;
    af_wr_en     = 1'b0;
    af_cmd_din   = '0;
    af_addr_din  = '0;
    wdf_wr_en    = 1'b0;
    wdf_data_din = '0;
    wdf_mask_din = '0;
    tag_push     = 1'b0;
    case (state_q)
      StIdle: begin
        if (sel_vld) state_d = StCmd;
      end
      StCmd: begin
        af_wr_en    = 1'b1;
        af_cmd_din  = {2'b00, ~we_q};
        af_addr_din = addr_q;
        if (!af_full) begin
          if (we_q) begin
            state_d = StWd0;
          end else begin
            state_d  = StIdle;
            tag_push = 1'b1;
          end
        end
      end
      StWd0: begin
        wdf_wr_en    = 1'b1;
        wdf_data_din = wdata_q[127:0];
        wdf_mask_din = wmask_q[15:0];
        if (!wdf_full) state_d = StWd1;
      end
      StWd1: begin
        wdf_wr_en    = 1'b1;
        wdf_data_din = wdata_q[255:128];
        wdf_mask_din = wmask_q[31:16];
        if (!wdf_full) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outstanding-read tag FIFO and beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RD_DEPTH); i++) tag_mem[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      beat_q   <= 1'b0;
    end else begin
      if (tag_push) begin
        tag_mem[wr_ptr_q] <= ptr_q;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      if (tag_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      // Stray beats with no tag do not advance the burst position.
      if (rdf_valid && !tag_empty) beat_q <= ~beat_q;
      if (tag_push && !tag_pop)      cnt_q <= cnt_q + 1'b1;
      else if (!tag_push && tag_pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Return path: always drain rdf, steer beats to the head tag's requester.
  always_comb begin
    rdf_rd_en = rdf_valid;
    rd_data   = tag_empty ? '0 : rdf_dout;
    rd_valid  = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      rd_valid[i] = rdf_valid & ~tag_empty & (head_tag == IW'(i));
    end
  end

  assign gnt            = gnt_q;
  assign rd_outstanding = cnt_q;

endmodule
